// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - decode/execute payload layout shared by the pipeline stages
package cpu_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;
   localparam int OP_W      = 3;

   // rs1_val, rs2_val, imm, rd, rs1, rs2, op, branch, spare
   localparam int DATA_W_DEFAULT = 3*XLEN + 3*REG_IDX_W + OP_W + 1 + 1;

   // Bit offsets of each field inside the packed payload (LSB first)
   localparam int RS1_VAL_LSB = 0;
   localparam int RS2_VAL_LSB = RS1_VAL_LSB + XLEN;
   localparam int IMM_LSB     = RS2_VAL_LSB + XLEN;
   localparam int RD_LSB      = IMM_LSB + XLEN;
   localparam int RS1_LSB     = RD_LSB + REG_IDX_W;
   localparam int RS2_LSB     = RS1_LSB + REG_IDX_W;
   localparam int OP_LSB      = RS2_LSB + REG_IDX_W;
   localparam int BRANCH_BIT  = OP_LSB + OP_W;
   localparam int SPARE_BIT   = BRANCH_BIT + 1;

   // Same layout as the offsets above; the first member lands in the MSBs
   typedef struct packed {
      logic                 spare;
      logic                 branch;
      logic [OP_W-1:0]      op;
      logic [REG_IDX_W-1:0] rs2;
      logic [REG_IDX_W-1:0] rs1;
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      imm;
      logic [XLEN-1:0]      rs2_val;
      logic [XLEN-1:0]      rs1_val;
   } id_ex_payload_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
//
// Ports:
//   clk_i  clock (rising edge)
//   rst_i  asynchronous active-low reset, clears the count
//   inc_i  count one event this cycle
//   clr_i  synchronous clear, wins over inc_i
//   cnt_o  current count, sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != {W{1'b1}})) begin
         cnt_o <= cnt_o + W'(1);
      end
   end

endmodule

// File: rtl/id_ex_pipe_skid.sv
// rtl/id_ex_pipe_skid.sv - ID/EX pipeline register with 2-entry skid buffer
//
// Ports:
//   clk_i        clock, all state updates on rising edge
//   rst_i        asynchronous active-low reset
//   flush_i      synchronous kill of both held entries
//   data_i       payload from decode, valid_i qualifies it
//   valid_i      decode presents payload
//   ready_o      buffer can accept (registered: skid entry empty)
//   data_o       payload to execute
//   valid_o      data_o holds a live instruction
//   ready_i      execute accepts data_o this cycle
//   count_o      occupancy 0..2
//   stall_cnt_o  saturating count of cycles with valid_o & ~ready_i
//   stall_clr_i  synchronous clear of stall_cnt_o
module id_ex_pipe_skid
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [1:0]        count_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   input  logic              stall_clr_i
);

   logic [DATA_W-1:0] m_data;
   logic [DATA_W-1:0] s_data;
   logic              m_vld;
   logic              s_vld;
   logic              in_fire;
   logic              out_fire;

   // ready_o depends only on the skid valid bit, so an execute stall never
   // forms a combinational path back into decode.
   assign ready_o  = ~s_vld;
   assign valid_o  = m_vld;
   assign data_o   = m_data;
   assign count_o  = {1'b0, m_vld} + {1'b0, s_vld};

   assign in_fire  = valid_i & ready_o;
   assign out_fire = m_vld & ready_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         m_data <= '0;
         s_data <= '0;
         m_vld  <= 1'b0;
         s_vld  <= 1'b0;
      end else if (flush_i) begin
         // Only the valid bits matter; stale data is never presented.
         m_vld <= 1'b0;
         s_vld <= 1'b0;
      end else if (!m_vld || out_fire) begin
         if (s_vld) begin
            m_data <= s_data;
            m_vld  <= 1'b1;
            s_vld  <= in_fire;
            if (in_fire) begin
               s_data <= data_i;
            end
         end else begin
            if (in_fire) begin
               m_data <= data_i;
            end
            m_vld <= in_fire;
         end
      end else if (in_fire) begin
         // Main is stalled: park the new item in the skid entry.
         s_data <= data_i;
         s_vld  <= 1'b1;
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (m_vld & ~ready_i),
      .clr_i (stall_clr_i),
      .cnt_o (stall_cnt_o)
   );

endmodule
